mem_port_sequencer: RTL and testbench

Multi-cycle sequencer that shares one external memory port between instruction fetch and data load/store for the RV32 core. It fetches the word at the current PC, holds it while the control unit and ALU settle, performs at most one data access, then pulses `cpu_en` for one cycle to commit the PC update and register write. It sits between `cpu_top` (which receives `cpu_en` as its `en`) and a single-ported memory with a req/ack handshake.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wait_timer.sv | 44 ++++
 rtl/mem_port_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 memory-port sequencer: state encoding,
// default access timeout and a small state classification helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd255;

    // States in which a memory request is outstanding and the wait timer runs.
    function automatic logic is_waiting(input state_e s);
        return (s == ST_FETCH) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Clear/enable wait counter; expired_o flags the last allowed cycle of a
// memory access so the sequencer can give up at the edge the count hits TIMEOUT.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: saturates at LAST so it can never wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one req/ack memory port between instruction fetch and data access,
// then pulses cpu_en for one cycle so the core commits the instruction.
module mem_port_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    input  logic                  dmem_wr,
    input  logic                  dmem_rd,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  cpu_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  err
);

    state_e                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   dmem_rdata_q, dmem_rdata_d;
    logic                    cpu_en_q, cpu_en_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    timer_expired_s;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (!is_waiting(state_q)),
        .enable_i  (is_waiting(state_q) && !mem_ack),
        .expired_o (timer_expired_s)
    );

    // Next-state and registered-output values; everything holds by default.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        instr_d      = instr_q;
        dmem_rdata_d = dmem_rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d   = ST_DECODE;
                    instr_d   = mem_rdata;
                    mem_req_d = 1'b0;
                end else if (timer_expired_s) begin
                    state_d   = ST_ERR;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // A store wins when both strobes are set, so no load data is captured.
                if (dmem_wr) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = dmem_addr;
                    mem_wdata_d = dmem_wdata;
                end else if (dmem_rd) begin
                    state_d    = ST_DATA;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = dmem_addr;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        dmem_rdata_d = mem_rdata;
                    end else begin
                        dmem_rdata_d = dmem_rdata_q;
                    end
                    state_d   = ST_COMMIT;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (timer_expired_s) begin
                    state_d   = ST_ERR;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_COMMIT: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d   = ST_ERR;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
        cpu_en_d = (state_d == ST_COMMIT);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_ERR);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            instr_q      <= '0;
            dmem_rdata_q <= '0;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_q      <= instr_d;
            dmem_rdata_q <= dmem_rdata_d;
            cpu_en_q     <= cpu_en_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign instr      = instr_q;
    assign dmem_rdata = dmem_rdata_q;
    assign cpu_en     = cpu_en_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: a table of single instructions
// plus hand-written back-to-back, start-drop, reset and timeout sequences.
module tb_mem_port_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc = '0;
    logic [DW-1:0] instr;
    logic          dmem_wr = 1'b0;
    logic          dmem_rd = 1'b0;
    logic [AW-1:0] dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic [DW-1:0] dmem_rdata;
    logic          cpu_en;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          err;

    always #5 clock = ~clock;

    mem_port_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .dmem_wr(dmem_wr), .dmem_rd(dmem_rd), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .cpu_en(cpu_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    // Memory model settings, written by the test process only.
    int          f_delay  = 0;
    int          d_delay  = 0;
    logic [31:0] f_word   = '0;
    logic [31:0] l_word   = '0;
    logic        spur_ack = 1'b0;

    // Monitor totals, written by the responder only.
    int          cyc = 0;
    int          req_cnt = 0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          stab_bad = 0;
    int          we_cycles = 0;
    int          last_en_cyc = 0;
    int          last_fetch_cyc = 0;
    logic [31:0] last_fetch_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    int          wcnt = 0;
    logic        nf = 1'b1;
    logic        cur_fetch = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we = 1'b0;

    // Memory responder and monitor, sampling on the falling edge.
    always @(negedge clock) begin
        int dly;
        cyc = cyc + 1;
        if (cpu_en) begin
            en_cnt = en_cnt + 1;
            last_en_cyc = cyc;
            nf = 1'b1;
        end
        if (!busy) nf = 1'b1;
        if (!mem_req) begin
            mem_ack = spur_ack;
            mem_rdata = 32'hFFFF0000;
            wcnt = 0;
        end else begin
            if (wcnt == 0) begin
                cur_fetch = nf;
                nf = 1'b0;
                req_cnt = req_cnt + 1;
                cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
                if (cur_fetch) begin
                    last_fetch_cyc = cyc;
                    last_fetch_addr = mem_addr;
                end
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                stab_bad = stab_bad + 1;
            end
            if (mem_we) we_cycles = we_cycles + 1;
            dly = cur_fetch ? f_delay : d_delay;
            if (wcnt == dly) begin
                mem_ack = 1'b1;
                mem_rdata = cur_fetch ? f_word : (mem_we ? 32'hBADC0DE5 : l_word);
                if (mem_we) begin
                    wr_cnt = wr_cnt + 1;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end
            end else begin
                mem_ack = 1'b0;
            end
            wcnt = wcnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock); #1;
        end
    endtask

    typedef struct {
        logic [31:0] pc, word;
        logic        wr, rd;
        logic [31:0] daddr, wdata, ldata;
        int          fdly, ddly;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_reqs, exp_wes;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int b_req, b_en, b_wr, b_stab, b_we;
        @(negedge clock); #1;
        pc = v.pc; dmem_wr = v.wr; dmem_rd = v.rd; dmem_addr = v.daddr; dmem_wdata = v.wdata;
        f_delay = v.fdly; d_delay = v.ddly; f_word = v.word; l_word = v.ldata;
        b_req = req_cnt; b_en = en_cnt; b_wr = wr_cnt; b_stab = stab_bad; b_we = we_cycles;
        start = 1'b1;
        for (int k = 0; k < 20 && req_cnt == b_req; k++) step(1);
        start = 1'b0;
        for (int k = 0; k < 40 && en_cnt == b_en; k++) step(1);
        step(2);
        chk($sformatf("v%0d instr", idx), instr, v.word);
        chk($sformatf("v%0d dmem_rdata", idx), dmem_rdata, v.exp_rdata);
        chk($sformatf("v%0d fetch_addr", idx), last_fetch_addr, v.pc);
        chk($sformatf("v%0d cpu_en_latency", idx), 32'(last_en_cyc - last_fetch_cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d cpu_en_count", idx), 32'(en_cnt - b_en), 32'd1);
        chk($sformatf("v%0d requests", idx), 32'(req_cnt - b_req), 32'(v.exp_reqs));
        chk($sformatf("v%0d we_cycles", idx), 32'(we_cycles - b_we), 32'(v.exp_wes));
        chk($sformatf("v%0d writes", idx), 32'(wr_cnt - b_wr), {31'd0, v.wr});
        chk($sformatf("v%0d stable", idx), 32'(stab_bad - b_stab), 32'd0);
        chk($sformatf("v%0d idle", idx), {31'd0, busy}, 32'd0);
        if (v.wr) begin
            chk($sformatf("v%0d wr_addr", idx), wr_addr, v.daddr);
            chk($sformatf("v%0d wr_data", idx), wr_data, v.wdata);
        end
    endtask

    initial begin
        int b_req, b_en, fc;
        vecs[0] = '{32'h0,  32'h00500093, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        0, 0, 32'h0,        2, 1, 0};
        vecs[1] = '{32'h4,  32'h0000A103, 1'b0, 1'b1, 32'h200, 32'h0,        32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 5, 2, 0};
        vecs[2] = '{32'h8,  32'h0020A023, 1'b1, 1'b1, 32'h100, 32'h1234,     32'h55555555, 0, 0, 32'hDEADBEEF, 3, 2, 1};
        vecs[3] = '{32'hC,  32'h002081B3, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        3, 0, 32'hDEADBEEF, 5, 1, 0};
        vecs[4] = '{32'h10, 32'h0040A203, 1'b0, 1'b1, 32'h204, 32'h0,        32'h0BADF00D, 1, 0, 32'h0BADF00D, 4, 2, 0};
        vecs[5] = '{32'h14, 32'h0030A423, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,        0, 1, 32'h0BADF00D, 4, 2, 2};

        #1 reset = 1'b0;
        #2;
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        step(2);
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Spurious ack in IDLE must be ignored.
        spur_ack = 1'b1;
        b_req = req_cnt;
        step(3);
        spur_ack = 1'b0;
        step(1);
        chk("spur instr", instr, 32'h0030A423);
        chk("spur busy", {31'd0, busy}, 32'd0);
        chk("spur requests", 32'(req_cnt - b_req), 32'd0);

        // Back-to-back: next fetch at the updated pc three cycles later.
        pc = 32'h40; f_word = 32'h00500093; f_delay = 0;
        dmem_wr = 1'b0; dmem_rd = 1'b0;
        b_req = req_cnt; b_en = en_cnt;
        start = 1'b1;
        for (int k = 0; k < 20 && req_cnt == b_req; k++) step(1);
        fc = last_fetch_cyc;
        chk("b2b first addr", last_fetch_addr, 32'h40);
        pc = 32'h44;
        for (int k = 0; k < 20 && req_cnt < b_req + 2; k++) step(1);
        chk("b2b next addr", last_fetch_addr, 32'h44);
        chk("b2b spacing", 32'(last_fetch_cyc - fc), 32'd3);
        start = 1'b0;
        for (int k = 0; k < 20 && en_cnt < b_en + 2; k++) step(1);
        step(2);
        chk("b2b commits", 32'(en_cnt - b_en), 32'd2);
        chk("b2b requests", 32'(req_cnt - b_req), 32'd2);
        chk("b2b idle", {31'd0, busy}, 32'd0);

        // start dropped while the load is outstanding.
        pc = 32'h50; f_word = 32'h0080A283; f_delay = 0;
        dmem_rd = 1'b1; dmem_addr = 32'h400; l_word = 32'h11223344; d_delay = 3;
        b_req = req_cnt; b_en = en_cnt;
        start = 1'b1;
        for (int k = 0; k < 20 && req_cnt < b_req + 2; k++) step(1);
        start = 1'b0;
        for (int k = 0; k < 20 && en_cnt == b_en; k++) step(1);
        step(3);
        chk("drop commits", 32'(en_cnt - b_en), 32'd1);
        chk("drop requests", 32'(req_cnt - b_req), 32'd2);
        chk("drop idle", {31'd0, busy}, 32'd0);
        chk("drop rdata", dmem_rdata, 32'h11223344);
        dmem_rd = 1'b0; d_delay = 0;

        // Reset while the fetch is waiting for ack.
        pc = 32'h80; f_delay = 1000;
        b_req = req_cnt;
        start = 1'b1;
        for (int k = 0; k < 20 && req_cnt == b_req; k++) step(1);
        start = 1'b0;
        step(1);
        chk("rf req before", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rf mem_req async", {31'd0, mem_req}, 32'd0);
        chk("rf busy async", {31'd0, busy}, 32'd0);
        step(1);
        chk("rf instr", instr, 32'd0);
        chk("rf dmem_rdata", dmem_rdata, 32'd0);
        chk("rf mem_addr", mem_addr, 32'd0);
        chk("rf mem_wdata", mem_wdata, 32'd0);
        chk("rf mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b1;
        b_req = req_cnt;
        step(3);
        chk("rf stays idle", 32'(req_cnt - b_req), 32'd0);
        chk("rf busy after", {31'd0, busy}, 32'd0);

        // Fetch never acked: ERR at the fourth unacked edge.
        pc = 32'h90; f_delay = 1000;
        b_req = req_cnt; b_en = en_cnt;
        start = 1'b1;
        for (int k = 0; k < 20 && req_cnt == b_req; k++) step(1);
        start = 1'b0;
        step(3);
        chk("to err early", {31'd0, err}, 32'd0);
        chk("to req held", {31'd0, mem_req}, 32'd1);
        step(1);
        chk("to err", {31'd0, err}, 32'd1);
        chk("to req dropped", {31'd0, mem_req}, 32'd0);
        chk("to busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        step(6);
        start = 1'b0;
        chk("to err sticky", {31'd0, err}, 32'd1);
        chk("to no cpu_en", 32'(en_cnt - b_en), 32'd0);
        chk("to no new req", 32'(req_cnt - b_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("to err cleared", {31'd0, err}, 32'd0);
        step(1);
        reset = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
